// File: rtl/btn_event_queue.sv
// Button event queue: latches debounced press pulses into a pending mask and
// serialises them, lowest index first, into a show-ahead FIFO with valid/ready.
module btn_event_queue #(
  parameter int N_BTN  = 5,
  parameter int DEPTH  = 4,
  parameter int CODE_W = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [N_BTN-1:0]         BTN_PULSE,
  input  logic                     EV_READY,
  input  logic                     OVF_CLR,
  output logic                     EV_VALID,
  output logic [CODE_W-1:0]        EV_CODE,
  output logic [$clog2(DEPTH):0]   EV_COUNT,
  output logic                     OVERFLOW
);
  localparam int AW = $clog2(DEPTH);

  logic [N_BTN-1:0]  r_pend;
  logic [AW-1:0]     r_wr, r_rd;
  logic [AW:0]       r_count;
  logic              r_ovf;
  logic [CODE_W-1:0] r_mem [DEPTH];

  logic [N_BTN-1:0]  w_sel, w_clr;
  logic [CODE_W-1:0] w_code;
  logic              w_pop, w_room, w_push, w_drop;

  assign w_pop  = EV_VALID && EV_READY;
  assign w_room = (r_count < (AW+1)'(DEPTH)) || w_pop;
  assign w_push = (|r_pend) && w_room;

  // Descending scan so the lowest set pending bit wins.
  always_comb begin
    w_sel  = '0;
    w_code = '0;
    for (int i = N_BTN-1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel  = N_BTN'(1) << i;
        w_code = CODE_W'(i+1);
      end
    end
  end

  assign w_clr  = w_push ? w_sel : '0;
  assign w_drop = |(BTN_PULSE & r_pend & ~w_clr);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pend  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      // A pulse landing on a bit being pushed re-arms it, so nothing is lost.
      r_pend <= (r_pend & ~w_clr) | BTN_PULSE;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_ovf <= 1'b1;
      else if (OVF_CLR) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr] <= w_code;
    end
  end

  assign EV_VALID = (r_count != '0);
  assign EV_CODE  = EV_VALID ? r_mem[r_rd] : '0;
  assign EV_COUNT = r_count;
  assign OVERFLOW = r_ovf;
endmodule

// File: tb/tb_btn_event_queue.sv
// Scoreboard bench for btn_event_queue: queue-based reference model drives
// expected codes into a scoreboard; a negedge monitor checks every pop.
module tb_btn_event_queue;
  localparam int N_BTN = 5, DEPTH = 4, CODE_W = 3, AW = $clog2(DEPTH);

  logic              CLK = 0, RESET = 1;
  logic [N_BTN-1:0]  BTN_PULSE = '0;
  logic              EV_READY = 0, OVF_CLR = 0;
  logic              EV_VALID, OVERFLOW;
  logic [CODE_W-1:0] EV_CODE;
  logic [AW:0]       EV_COUNT;

  btn_event_queue #(.N_BTN(N_BTN), .DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
    .CLK(CLK), .RESET(RESET), .BTN_PULSE(BTN_PULSE), .EV_READY(EV_READY),
    .OVF_CLR(OVF_CLR), .EV_VALID(EV_VALID), .EV_CODE(EV_CODE),
    .EV_COUNT(EV_COUNT), .OVERFLOW(OVERFLOW));

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int sb[$];               // expected codes in pop order
  int m_q[$];              // model FIFO contents
  bit [N_BTN-1:0] m_pend;
  bit m_ovf;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: effect of one clock edge given the inputs presented before it.
  task automatic model_edge(bit [N_BTN-1:0] b, bit r, bit c);
    bit pop, room, drop;
    int sel;
    pop  = (m_q.size() > 0) && r;
    room = (m_q.size() < DEPTH) || pop;
    sel  = -1;
    if (room)
      for (int i = N_BTN-1; i >= 0; i--) if (m_pend[i]) sel = i;
    if (pop) void'(m_q.pop_front());
    if (sel >= 0) begin
      m_q.push_back(sel + 1);
      sb.push_back(sel + 1);
      m_pend[sel] = 1'b0;
    end
    drop = 0;
    for (int i = 0; i < N_BTN; i++)
      if (b[i] && m_pend[i]) drop = 1;
    m_pend = m_pend | b;
    if (drop) m_ovf = 1;
    else if (c) m_ovf = 0;
  endtask

  task automatic check_state();
    chk("EV_VALID", int'(EV_VALID), int'(m_q.size() != 0));
    chk("EV_COUNT", int'(EV_COUNT), m_q.size());
    chk("OVERFLOW", int'(OVERFLOW), int'(m_ovf));
  endtask

  // Called just after a posedge; inputs are held across the next edge.
  task automatic step(bit [N_BTN-1:0] b, bit r, bit c);
    BTN_PULSE = b; EV_READY = r; OVF_CLR = c;
    model_edge(b, r, c);
    @(posedge CLK); #1;
    check_state();
  endtask

  task automatic idle(int n, bit r);
    for (int i = 0; i < n; i++) step('0, r, 0);
  endtask

  task automatic do_reset();
    RESET = 1; BTN_PULSE = '0; EV_READY = 0; OVF_CLR = 0;
    #1;
    chk("rst EV_VALID", int'(EV_VALID), 0);
    chk("rst EV_CODE",  int'(EV_CODE), 0);
    chk("rst EV_COUNT", int'(EV_COUNT), 0);
    chk("rst OVERFLOW", int'(OVERFLOW), 0);
    m_q.delete(); sb.delete(); m_pend = '0; m_ovf = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESET = 0;
    @(posedge CLK); #1;
    check_state();
  endtask

  // Monitor: inputs are stable at negedge, so a valid&&ready seen here is a pop.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (!EV_VALID) chk("EV_CODE idle", int'(EV_CODE), 0);
      else if (EV_READY) begin
        if (sb.size() == 0) chk("unexpected pop", int'(EV_CODE), 0);
        else chk("pop code", int'(EV_CODE), sb.pop_front());
      end
    end
  end

  initial begin
    do_reset();
    // single press, two-cycle latency, then pop
    step(5'b00010, 0, 0);
    chk("lat1 EV_VALID", int'(EV_VALID), 0);
    step('0, 0, 0);
    chk("lat2 EV_CODE", int'(EV_CODE), 2);
    step('0, 1, 0);
    idle(1, 0);
    // simultaneous presses serialise 1,3,5
    step(5'b10101, 0, 0);
    idle(3, 0);
    chk("simul count", int'(EV_COUNT), 3);
    idle(4, 1);
    // full FIFO: pending holds, second pulse drops, refill on first pop
    step(5'b01111, 0, 0);
    idle(4, 0);
    step(5'b01000, 0, 0);
    idle(1, 0);
    chk("full no ovf", int'(OVERFLOW), 0);
    step(5'b01000, 0, 0);
    chk("full drop ovf", int'(OVERFLOW), 1);
    step('0, 1, 0);
    chk("pop+push count", int'(EV_COUNT), 4);
    idle(6, 1);
    step('0, 0, 1);
    // set/clear collision gives two code-2 events
    step(5'b00010, 0, 0);
    step(5'b00010, 0, 0);
    idle(2, 0);
    chk("collide count", int'(EV_COUNT), 2);
    idle(3, 1);
    // pointer wrap with interleaved pops
    for (int k = 0; k < 10; k++) begin
      step(N_BTN'(1) << (k % N_BTN), 1, 0);
      step('0, 1, 0);
    end
    idle(3, 1);
    // mid-operation reset with 3 queued and 2 pending
    step(5'b11111, 0, 0);
    idle(3, 0);
    chk("pre-rst count", int'(EV_COUNT), 3);
    do_reset();
    idle(8, 1);
    // drop together with OVF_CLR: set wins, then clear alone
    step(5'b01111, 0, 0);
    idle(4, 0);
    step(5'b00001, 0, 0);
    step(5'b00001, 0, 1);
    chk("set wins", int'(OVERFLOW), 1);
    step('0, 0, 1);
    chk("ovf clr", int'(OVERFLOW), 0);
    idle(6, 1);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bit [N_BTN-1:0] b;
      for (int i = 0; i < N_BTN; i++) b[i] = ($urandom_range(0, 7) == 0);
      step(b, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    idle(20, 1);
    chk("sb drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
